// File: rtl/stack_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_access_arbiter_if
// Purpose  : Bundles the requester handshake and the stack-side strobes of
//            stack_access_arbiter. The master modport is the requester/stack
//            side. The slave modport is the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface stack_access_arbiter_if #(
  parameter int N    = 8,
  parameter int REQS = 4,
  parameter int AW   = 13
);
  logic [REQS-1:0]   req_push;
  logic [REQS-1:0]   req_pop;
  logic [REQS*N-1:0] req_data;
  logic [REQS-1:0]   ack;
  logic              rsp_err;
  logic [N-1:0]      rsp_data;
  logic              stk_push;
  logic              stk_pop;
  logic [N-1:0]      stk_din;
  logic [N-1:0]      stk_dout;
  logic              stk_empty;
  logic [AW:0]       occupancy;

  modport master (
    output req_push, req_pop, req_data, stk_dout, stk_empty,
    input  ack, rsp_err, rsp_data, stk_push, stk_pop, stk_din, occupancy
  );

  modport slave (
    input  req_push, req_pop, req_data, stk_dout, stk_empty,
    output ack, rsp_err, rsp_data, stk_push, stk_pop, stk_din, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/stack_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stack_access_arbiter
// Purpose  : Shares one stack between REQS requesters. Push and pop requests
//            are arbitrated and run one at a time (IDLE -> EXEC -> RESP).
//            Occupancy is tracked so that overflow and underflow are rejected.
// Options  : STACK_ARB_FIXED_PRIO_EN - when defined, the lowest pending index
//            always wins and no round-robin pointer is built.
// Revision : 1.0 - initial release
// ============================================================================
module stack_access_arbiter #(
  parameter int N    = 8,
  parameter int REQS = 4,
  parameter int AW   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  stack_access_arbiter_if.slave bus
);

  localparam int          c_IW    = (REQS > 1) ? $clog2(REQS) : 1;
  localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_EXEC = c_ST_EXEC,
    ST_RESP = c_ST_RESP
  } state_t;

  state_t          r_state;
  logic [c_IW-1:0] r_idx;
  logic            r_err;

  logic [REQS-1:0] w_pending;
  logic            w_found;
  logic [c_IW-1:0] w_sel;
  logic [c_IW-1:0] w_base;
  logic            w_sel_push;
  logic            w_sel_pop;

  assign w_pending  = bus.req_push | bus.req_pop;
  assign w_sel_push = bus.req_push[w_sel];
  assign w_sel_pop  = bus.req_pop[w_sel];

`ifdef STACK_ARB_FIXED_PRIO_EN
  // The search always starts at requester 0, so the lowest pending index wins.
  assign w_base = '0;
`else
  localparam logic [c_IW-1:0] c_LAST = c_IW'(REQS - 1);

  logic [c_IW-1:0] r_rr_ptr;

  // Advance the round-robin pointer past the requester just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (r_state == ST_RESP) begin
      r_rr_ptr <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  assign w_base = r_rr_ptr;
`endif

  // Pick the first pending requester at or after the search base, wrapping.
  always_comb begin : sel_proc
    int j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < REQS; k++) begin
      j = int'(w_base) + k;
      if (j >= REQS) j = j - REQS;
      if (!w_found && w_pending[j]) begin
        w_found = 1'b1;
        w_sel   = c_IW'(j);
      end
    end
  end

  // Operation sequencer. The strobe decision is made on grant, so strobes
  // are registered and high for exactly the EXEC cycle. Occupancy and pop
  // data are committed on the edge that ends EXEC, together with the stack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_err         <= 1'b0;
      bus.ack       <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_data  <= '0;
      bus.stk_push  <= 1'b0;
      bus.stk_pop   <= 1'b0;
      bus.stk_din   <= '0;
      bus.occupancy <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_idx       <= w_sel;
            bus.stk_din <= bus.req_data[w_sel*N +: N];
            r_state     <= ST_EXEC;
            if (w_sel_push && w_sel_pop) begin
              // A simultaneous push and pop is illegal. It is rejected with no strobe.
              r_err <= 1'b1;
            end else if (w_sel_push) begin
              if (bus.occupancy < c_DEPTH) begin
                bus.stk_push <= 1'b1;
                r_err        <= 1'b0;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              if ((bus.occupancy != '0) && !bus.stk_empty) begin
                bus.stk_pop <= 1'b1;
                r_err       <= 1'b0;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        end
        ST_EXEC: begin
          bus.stk_push <= 1'b0;
          bus.stk_pop  <= 1'b0;
          if (bus.stk_push) begin
            bus.occupancy <= bus.occupancy + 1'b1;
          end
          if (bus.stk_pop) begin
            bus.occupancy <= bus.occupancy - 1'b1;
            bus.rsp_data  <= bus.stk_dout;
          end
          bus.ack     <= REQS'(1) << r_idx;
          bus.rsp_err <= r_err;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          bus.ack     <= '0;
          bus.rsp_err <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_access_arbiter
// Purpose  : Directed self-checking bench for stack_access_arbiter. It uses
//            AW=3, with a behavioural stack and a scoreboard of expected
//            responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_access_arbiter;
  localparam int N     = 8;
  localparam int REQS  = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [REQS-1:0]   req_push = '0;
  logic [REQS-1:0]   req_pop  = '0;
  logic [REQS*N-1:0] req_data = '0;

  stack_access_arbiter_if #(.N(N), .REQS(REQS), .AW(AW)) bus ();

  stack_access_arbiter #(.N(N), .REQS(REQS), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_push = req_push;
  assign bus.req_pop  = req_pop;
  assign bus.req_data = req_data;

  // Behavioural stack. d_out shows the current top of the stack.
  logic [N-1:0] mem [0:DEPTH-1];
  int sp = 0;
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (bus.stk_push && sp < DEPTH) begin
      mem[sp] <= bus.stk_din;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) sp <= sp - 1;
  end
  assign bus.stk_dout  = (sp > 0) ? mem[sp-1] : '0;
  assign bus.stk_empty = (sp == 0);

  // Strobe monitor.
  int push_cnt = 0, pop_cnt = 0, both_cnt = 0;
  logic [N-1:0] last_din = '0;
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.stk_push) begin
        push_cnt <= push_cnt + 1;
        last_din <= bus.stk_din;
      end
      if (bus.stk_pop) pop_cnt <= pop_cnt + 1;
      if (bus.stk_push && bus.stk_pop) both_cnt <= both_cnt + 1;
    end
  end

  typedef struct {
    int           idx;
    logic         err;
    int           npush;
    int           npop;
    logic [N-1:0] din;
    logic [N-1:0] data;
    int           occ;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] ref_q[$];
  int           m_occ = 0;
  logic [N-1:0] m_last = '0;
  int           last_push = 0, last_pop = 0;
  int           checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: predicts one operation and queues the expected response.
  task automatic model(input int i, input bit p, input bit q, input logic [N-1:0] d);
    exp_t e;
    e.idx = i; e.npush = 0; e.npop = 0; e.din = d; e.err = 1'b1;
    if (p && q) begin
      e.err = 1'b1;
    end else if (p) begin
      if (m_occ < DEPTH) begin
        ref_q.push_back(d); m_occ++; e.npush = 1; e.err = 1'b0;
      end
    end else begin
      if (m_occ > 0) begin
        m_last = ref_q.pop_back(); m_occ--; e.npop = 1; e.err = 1'b0;
      end
    end
    e.occ = m_occ; e.data = m_last;
    sb.push_back(e);
  endtask

  // Wait for ack (bounded), then compare against the scoreboard head.
  task automatic check_resp(input int exp_lat);
    int n;
    exp_t e;
    n = 0;
    while (bus.ack == '0 && n < 12) begin
      @(negedge clk); n++;
    end
    checks++;
    assert (bus.ack !== '0) else begin
      errors++;
      $error("FAIL ack_wait: observed no ack after %0d cycles, expected an ack", n);
    end
    e = sb.pop_front();
    chk("ack", 32'(bus.ack), 32'(1) << e.idx);
    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
    chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
    chk("push_strobes", 32'(push_cnt - last_push), 32'(e.npush));
    chk("pop_strobes", 32'(pop_cnt - last_pop), 32'(e.npop));
    chk("occupancy", 32'(bus.occupancy), 32'(e.occ));
    if (e.npush == 1) chk("stk_din", 32'(last_din), 32'(e.din));
    if (exp_lat >= 0) chk("latency", 32'(n), 32'(exp_lat));
    last_push = push_cnt;
    last_pop  = pop_cnt;
  endtask

  // One request from one requester, dropped on its ack cycle.
  task automatic op(input int i, input bit p, input bit q, input logic [N-1:0] d);
    model(i, p, q, d);
    @(negedge clk);
    req_push[i] = p; req_pop[i] = q; req_data[i*N +: N] = d;
    check_resp(2);
    req_push[i] = 1'b0; req_pop[i] = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    int ord[6];
    int seen;
`ifdef STACK_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0, 0, 0};
`else
    ord = '{0, 1, 3, 0, 1, 3};
`endif
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_strobes", 32'({bus.stk_push, bus.stk_pop}), 0);
    chk("rst_rsp", 32'({bus.rsp_err, bus.rsp_data}), 0);
    chk("rst_din", 32'(bus.stk_din), 0);
    rst = 1'b0;

    op(0, 1, 0, 8'h5A);           // first push
    op(1, 1, 1, 8'hEE);           // illegal push+pop
    op(2, 0, 1, 8'h00);           // pop returns 0x5A
    op(2, 0, 1, 8'h00);           // underflow
    op(3, 0, 1, 8'h00);           // underflow, moves the pointer back to 0

    // Requesters 0, 1 and 3 push continuously.
    for (int g = 0; g < 6; g++) model(ord[g], 1, 0, 8'(8'h10 + ord[g]));
    @(negedge clk);
    for (int i = 0; i < REQS; i++) begin
      if (i != 2) begin
        req_push[i] = 1'b1;
        req_data[i*N +: N] = 8'(8'h10 + i);
      end
    end
    for (int g = 0; g < 6; g++) begin
      check_resp(-1);
      if (g == 5) req_push = '0;
      else begin
        req_push[ord[g]] = 1'b0;
        @(negedge clk);
        req_push[ord[g]] = 1'b1;
      end
    end

    op(2, 1, 0, 8'h20);
    op(2, 1, 0, 8'h21);           // full
    op(0, 1, 0, 8'h99);           // overflow
    for (int k = 0; k < DEPTH; k++) op(1, 0, 1, 8'h00);
    op(0, 1, 0, 8'h77);

    // Reset during EXEC of a push.
    @(negedge clk);
    req_push[3] = 1'b1; req_data[3*N +: N] = 8'h33;
    @(negedge clk);
    chk("exec_push", 32'(bus.stk_push), 1);
    chk("exec_din", 32'(bus.stk_din), 32'h33);
    rst = 1'b1; req_push[3] = 1'b0;
    @(negedge clk);
    chk("mid_rst_ack", 32'(bus.ack), 0);
    chk("mid_rst_occ", 32'(bus.occupancy), 0);
    chk("mid_rst_strobes", 32'({bus.stk_push, bus.stk_pop}), 0);
    chk("mid_rst_rsp", 32'({bus.rsp_err, bus.rsp_data}), 0);
    chk("mid_rst_din", 32'(bus.stk_din), 0);
    rst = 1'b0;
    m_occ = 0; ref_q.delete(); m_last = '0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack != '0) seen = 1;
    end
    chk("no_ack_after_rst", 32'(seen), 0);
    last_push = push_cnt; last_pop = pop_cnt;
    op(1, 1, 0, 8'h42);

    chk("strobe_overlap", 32'(both_cnt), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stack_access_arbiter.md
Name: stack_access_arbiter

Overview:
- Shares one stack instance (N-bit data, 2^AW entries) between REQS requesters.
- Arbitrates push/pop requests round-robin, sequences the stack's push/pop strobes one operation at a time, and tracks occupancy so overflow and underflow are rejected.
- Returns popped data or an error flag to the granted requester.
- Sits between client FSMs and the stack; the stack's tos input is tied low by the integrator.

Parameters:
- N, 8, data width
- REQS, 4, number of requesters (2..8)
- AW, 13, stack address width; capacity DEPTH = 2^AW entries

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_push  in  REQS  per-requester push request, level, held until ack
- req_pop  in  REQS  per-requester pop request, level, held until ack
- req_data  in  REQS*N  push data; requester i uses bits [i*N +: N]
- ack  out  REQS  one-hot, 1-cycle pulse: request of requester i completed
- rsp_err  out  1  valid with ack: operation rejected
- rsp_data  out  N  valid with ack on a successful pop
- stk_push  out  1  to stack push
- stk_pop  out  1  to stack pop
- stk_din  out  N  to stack d_in
- stk_dout  in  N  from stack d_out
- stk_empty  in  1  from stack empty
- occupancy  out  AW+1  current entry count, 0..DEPTH

Behaviour:
- Reset values: state IDLE; ack=0, rsp_err=0, rsp_data=0, stk_push=0, stk_pop=0, stk_din=0, occupancy=0; RR pointer=0 (requester 0 has highest priority first).
- Reset mid-operation: any in-flight operation is abandoned with no ack. The integrator resets the stack with the same rst.
- A requester is pending if req_push[i] or req_pop[i] is set.
- State IDLE:
  - With any requester pending, select the first pending index at or after the RR pointer, wrapping modulo REQS. Latch index, op and data. Go to EXEC.
  - With none pending, stay in IDLE.
- State EXEC (1 cycle):
  - Push with occupancy < DEPTH: stk_push=1, stk_din=latched data, occupancy+1.
  - Pop with occupancy > 0 and stk_empty=0: stk_pop=1, occupancy-1.
  - Otherwise no strobe; mark error.
  - Always go to RESP.
- State RESP (1 cycle):
  - ack[idx]=1.
  - rsp_err=1 on overflow, on underflow, or when both req_push[idx] and req_pop[idx] were set at grant. The simultaneous push+pop case is illegal: no stack strobe, occupancy unchanged.
  - On a successful pop, rsp_data=stk_dout (the stack updates d_out in the EXEC cycle). Otherwise rsp_data holds its previous value.
  - RR pointer = idx+1 mod REQS. Go to IDLE.
- Latency: request seen in IDLE at cycle t → ack at t+2. Each operation takes 3 cycles including the IDLE cycle. Throughput is one operation per 3 cycles.
- Requesters deassert on the ack cycle. A request still high in the following IDLE cycle is treated as a new request.
- Request changes after grant are ignored until ack; the latched op and data are used.
- occupancy never wraps. A push at DEPTH and a pop at 0 both error, with no strobe.
- Strobes: stk_push and stk_pop are never asserted together and are each high only during EXEC.

Optional Feature:
- Macro: STACK_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest pending index always wins and the RR pointer is not implemented.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset, then req_push[0]=1 with data 0x5A → stk_push pulse with stk_din=0x5A; ack=0001 two cycles later; rsp_err=0; occupancy=1.
- Pop on requester 2 after that push → ack=0100, rsp_data=0x5A, rsp_err=0, occupancy=0. A second pop → rsp_err=1, no stk_pop pulse.
- Requesters 0, 1 and 3 all push continuously (0x10, 0x11, 0x13) → grant order 0,1,3,0,1,3. With STACK_ARB_FIXED_PRIO_EN defined, the order is 0,0,0.
- Fill to DEPTH (AW=3 build, 8 pushes), then a 9th push → rsp_err=1, no stk_push, occupancy stays 8.
- req_push[1] and req_pop[1] set together → ack=0010 with rsp_err=1, no strobe, occupancy unchanged.
- rst asserted during EXEC of a push → next cycle all outputs at reset values, occupancy=0, no ack issued.
